// File: rtl/mem_bank_ctrl.sv
// mem_bank_ctrl: single-outstanding read/write controller for two fixed-latency memory banks
`timescale 1ns/1ps
module mem_bank_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 20,
    parameter int BANK0_LAT   = 1,
    parameter int BANK1_LAT   = 3,
    parameter int BANK0_DEPTH = 819199,
    parameter int BANK1_DEPTH = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_select,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              b0_en,
    output logic              b0_we,
    output logic [ADDR_W-1:0] b0_addr,
    output logic [DATA_W-1:0] b0_wdata,
    input  logic [DATA_W-1:0] b0_rdata,
    output logic              b1_en,
    output logic              b1_we,
    output logic [ADDR_W-1:0] b1_addr,
    output logic [DATA_W-1:0] b1_wdata,
    input  logic [DATA_W-1:0] b1_rdata
);
    localparam int MAX_LAT = (BANK0_LAT > BANK1_LAT) ? BANK0_LAT : BANK1_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              req_err;
    logic              issue0, issue1;

    assign req_err = req_select[1] |
                     (req_select[0] ? longint'(req_addr) >= longint'(BANK1_DEPTH)
                                    : longint'(req_addr) >= longint'(BANK0_DEPTH));

    assign req_ready  = (state_q == IDLE) & ~rst;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Bank strobes come only from registered state and the latched request, so they are clean.
    assign issue0   = (state_q == ISSUE) && (sel_q == 2'b00);
    assign issue1   = (state_q == ISSUE) && (sel_q == 2'b01);
    assign b0_en    = issue0;
    assign b0_we    = issue0 & we_q;
    assign b0_addr  = issue0 ? addr_q : '0;
    assign b0_wdata = issue0 ? wdata_q : '0;
    assign b1_en    = issue1;
    assign b1_we    = issue1 & we_q;
    assign b1_addr  = issue1 ? addr_q : '0;
    assign b1_wdata = issue1 ? wdata_q : '0;

    // Next-state: accept, issue to the bank, count out its latency, then hold the response.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid && req_ready) begin
                we_d    = req_we;
                sel_d   = req_select;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                state_d = req_err ? RESP : ISSUE;
                valid_d = req_err;
                err_d   = req_err;
                rdata_d = '0;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = sel_q[0] ? CNT_W'(BANK1_LAT) : CNT_W'(BANK0_LAT);
            end
            WAIT: if (cnt_q == CNT_W'(1)) begin
                state_d = RESP;
                valid_d = 1'b1;
                rdata_d = we_q ? '0 : (sel_q[0] ? b1_rdata : b0_rdata);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            RESP: if (resp_ready) begin
                state_d = IDLE;
                valid_d = 1'b0;
                err_d   = 1'b0;
                rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request; reset drops any transaction in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_bank_ctrl.sv
// tb_mem_bank_ctrl: randomized bench for mem_bank_ctrl with bank models and a reference memory
`timescale 1ns/1ps
module tb_mem_bank_ctrl;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam int D0   = 819199;
    localparam int D1   = 1048576;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [1:0]  req_select = '0;
    logic [19:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0] resp_rdata;
    logic        b0_en, b0_we, b1_en, b1_we;
    logic [19:0] b0_addr, b1_addr;
    logic [31:0] b0_wdata, b1_wdata, b0_rdata = '0, b1_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] bmem0[int], bmem1[int], rmem0[int], rmem1[int];

    always #5 clk = ~clk;

    mem_bank_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_select(req_select), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .b0_en(b0_en), .b0_we(b0_we), .b0_addr(b0_addr), .b0_wdata(b0_wdata), .b0_rdata(b0_rdata),
        .b1_en(b1_en), .b1_we(b1_we), .b1_addr(b1_addr), .b1_wdata(b1_wdata), .b1_rdata(b1_rdata)
    );

    function automatic logic [31:0] init_word(input int bank, input int a);
        return ((32'(a) + 32'd1) * 32'h9E3779B9) ^ (bank != 0 ? 32'hA5A50000 : 32'h0);
    endfunction

    function automatic logic [31:0] ref_rd(input int bank, input int a);
        if (bank != 0) return rmem1.exists(a) ? rmem1[a] : init_word(1, a);
        return rmem0.exists(a) ? rmem0[a] : init_word(0, a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bank models: rdata is valid only LAT cycles after the enable, noise otherwise.
    int k0 = 0, k1 = 0, pa0 = 0, pa1 = 0;
    always @(posedge clk) begin
        b0_rdata <= $urandom;
        b1_rdata <= $urandom;
        if (b0_en) begin
            if (b0_we) bmem0[int'(b0_addr)] = b0_wdata;
            else begin pa0 = int'(b0_addr); k0 = LAT0; end
        end
        if (b1_en) begin
            if (b1_we) bmem1[int'(b1_addr)] = b1_wdata;
            else begin pa1 = int'(b1_addr); k1 = LAT1; end
        end
        if (k0 != 0) begin
            if (k0 == 1) b0_rdata <= bmem0.exists(pa0) ? bmem0[pa0] : init_word(0, pa0);
            k0--;
        end
        if (k1 != 0) begin
            if (k1 == 1) b1_rdata <= bmem1.exists(pa1) ? bmem1[pa1] : init_word(1, pa1);
            k1--;
        end
    end

    task automatic junk_req(input logic v);
        req_valid  = v;
        req_we     = 1'($urandom);
        req_select = 2'($urandom);
        req_addr   = 20'($urandom);
        req_wdata  = $urandom;
    endtask

    // Called at a negedge with the controller idle; returns at a negedge with it idle again.
    task automatic run_txn(input logic we, input logic [1:0] sel, input logic [19:0] addr,
                           input logic [31:0] wd, input int hold);
        logic err, go0, go1;
        int lat;
        logic [31:0] exp_rd;
        err = sel[1] || (sel == 2'b00 && int'(addr) >= D0) || (sel == 2'b01 && int'(addr) >= D1);
        go0 = !err && sel == 2'b00;
        go1 = !err && sel == 2'b01;
        lat = err ? 1 : 2 + (sel[0] ? LAT1 : LAT0);
        exp_rd = (err || we) ? 32'h0 : ref_rd(int'(sel[0]), int'(addr));
        if (!err && we) begin
            if (sel[0]) rmem1[int'(addr)] = wd;
            else rmem0[int'(addr)] = wd;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_select = sel; req_addr = addr; req_wdata = wd;
        resp_ready = 1'b0;
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            chk("resp_valid_timing", 32'(resp_valid), 32'(n == lat));
            chk("b0_en", 32'(b0_en), 32'(n == 1 && go0));
            chk("b1_en", 32'(b1_en), 32'(n == 1 && go1));
            chk("b0_we", 32'(b0_we), 32'(n == 1 && go0 && we));
            chk("b1_we", 32'(b1_we), 32'(n == 1 && go1 && we));
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (n == 1 && go0) begin
                chk("b0_addr", 32'(b0_addr), 32'(addr));
                chk("b0_wdata", b0_wdata, wd);
            end
            if (n == 1 && go1) begin
                chk("b1_addr", 32'(b1_addr), 32'(addr));
                chk("b1_wdata", b1_wdata, wd);
            end
            junk_req(1'($urandom));
        end
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", 32'(resp_err), 32'(err));
        repeat (hold) begin
            @(negedge clk);
            chk("resp_valid_hold", 32'(resp_valid), 32'd1);
            chk("resp_rdata_hold", resp_rdata, exp_rd);
            chk("resp_err_hold", 32'(resp_err), 32'(err));
            chk("req_ready_resp", 32'(req_ready), 32'd0);
            chk("bank_en_resp", 32'({b0_en, b1_en}), 32'd0);
            junk_req(1'b1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("resp_valid_drop", 32'(resp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
    endtask

    // Start a bank-1 read, then assert reset after `cyc` cycles in flight.
    task automatic reset_mid(input int cyc);
        chk("req_ready_pre_rst", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b0; req_select = 2'b01; req_addr = 20'h5; req_wdata = '0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_b1_en_issue", 32'(b1_en), 32'd1);
        repeat (cyc - 1) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_b1_en_drop", 32'(b1_en), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        repeat (8) begin
            @(negedge clk);
            chk("no_stale_resp", 32'(resp_valid), 32'd0);
            chk("no_stale_en", 32'({b0_en, b1_en}), 32'd0);
        end
    endtask

    int r;
    logic [19:0] a;
    logic [1:0]  s;

    initial begin
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_bank_en", 32'({b0_en, b1_en, b0_we, b1_we}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bmem0[16] = 32'hDEADBEEF; rmem0[16] = 32'hDEADBEEF;
        run_txn(1'b0, 2'b00, 20'h00010, 32'h0, 0);
        bmem1[5] = 32'hCAFEF00D; rmem1[5] = 32'hCAFEF00D;
        run_txn(1'b0, 2'b01, 20'h00005, 32'h0, 0);
        run_txn(1'b1, 2'b00, 20'h00020, 32'h12345678, 0);
        run_txn(1'b0, 2'b00, 20'h00020, 32'h0, 1);
        run_txn(1'b0, 2'b10, 20'h0, 32'h0, 0);
        run_txn(1'b0, 2'b00, 20'(819199), 32'h0, 0);
        run_txn(1'b1, 2'b00, 20'(819198), 32'h55AA55AA, 0);
        run_txn(1'b0, 2'b00, 20'(819198), 32'h0, 0);
        run_txn(1'b0, 2'b01, 20'hFFFFF, 32'h0, 0);
        run_txn(1'b1, 2'b11, 20'h3, 32'h1, 2);
        run_txn(1'b0, 2'b01, 20'h00005, 32'h0, 4);
        run_txn(1'b1, 2'b01, 20'h00007, 32'h0BADCAFE, 0);
        run_txn(1'b0, 2'b01, 20'h00007, 32'h0, 0);
        reset_mid(2);
        reset_mid(1);
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 9);
            s = r < 4 ? 2'b00 : r < 8 ? 2'b01 : {1'b1, 1'($urandom)};
            r = $urandom_range(0, 9);
            case (r)
                0: a = 20'(819198);
                1: a = 20'(819199);
                2: a = 20'(819200);
                3: a = 20'hFFFFF;
                4: a = 20'($urandom);
                default: a = 20'($urandom_range(0, 15));
            endcase
            run_txn(1'($urandom), s, a, $urandom, $urandom_range(0, 3));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
